// File: rtl/btb_port_scheduler_if.sv
// Signal bundle between IF, branch resolve, the BTB and the BTB port scheduler.
// slave is the scheduler's view; master is the surrounding pipeline/BTB view.
interface btb_port_scheduler_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        stall_fetch;
    logic        pred_valid;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        btb_access;
    logic [31:0] btb_lookup_pc;
    logic        btb_found;
    logic [31:0] btb_predict_pc;
    logic        btb_update;
    logic [31:0] btb_upd_pc;
    logic [31:0] btb_upd_target;

    modport slave (
        input  fetch_valid, fetch_pc, res_valid, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target, btb_found, btb_predict_pc,
        output stall_fetch, pred_valid, pred_target, res_ready, flush, redirect_pc,
               btb_access, btb_lookup_pc, btb_update, btb_upd_pc, btb_upd_target
    );

    modport master (
        output fetch_valid, fetch_pc, res_valid, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target, btb_found, btb_predict_pc,
        input  stall_fetch, pred_valid, pred_target, res_ready, flush, redirect_pc,
               btb_access, btb_lookup_pc, btb_update, btb_upd_pc, btb_upd_target
    );
endinterface

// File: rtl/btb_port_scheduler.sv
// Arbitrates the single BTB index port between fetch lookups and queued
// resolve-stage updates; flags mispredictions as a one-cycle flush + redirect.
module btb_port_scheduler #(
    parameter int unsigned QDEPTH       = 4,
    parameter int unsigned QPTR_W       = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 reset,
    btb_port_scheduler_if.slave bus
);
    localparam int unsigned      AGE_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [QPTR_W:0]  FULL_CNT = (QPTR_W + 1)'(QDEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {ST_RUN, ST_FORCE, ST_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [QPTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [QPTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [QPTR_W:0]     count_q, count_d;
    logic [AGE_W-1:0]    age_q, age_d;
    logic [31:0]         redirect_q, redirect_d;
    logic [31:0]         mem_pc_q  [QDEPTH];
    logic [31:0]         mem_pc_d  [QDEPTH];
    logic [31:0]         mem_tgt_q [QDEPTH];
    logic [31:0]         mem_tgt_d [QDEPTH];

    logic        count_nz;
    logic        ready;
    logic        enq;
    logic        mis_acc;
    logic [31:0] enq_tgt;
    logic        lookup_grant;
    logic        update_grant;
    logic        stall;

    assign count_nz = (count_q != '0);
    assign ready    = (count_q < FULL_CNT);
    assign enq      = bus.res_valid && ready;
    assign enq_tgt  = bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;
    assign mis_acc  = enq && ((bus.res_taken != bus.res_pred_taken) ||
                              (bus.res_taken && (bus.res_target != bus.res_pred_target)));

    always_comb begin
        lookup_grant = 1'b0;
        update_grant = 1'b0;
        stall        = 1'b0;
        case (state_q)
            ST_RUN: begin
                lookup_grant = bus.fetch_valid;
                update_grant = !bus.fetch_valid && count_nz;
            end
            ST_FORCE: begin
                update_grant = count_nz;
                stall        = bus.fetch_valid;
            end
            ST_FLUSH: begin
                update_grant = count_nz;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_pc_d  = mem_pc_q;
        mem_tgt_d = mem_tgt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (enq) begin
            mem_pc_d[wr_ptr_q]  = bus.res_pc;
            mem_tgt_d[wr_ptr_q] = enq_tgt;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (update_grant) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({enq, update_grant})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        age_d = age_q;
        if (update_grant || !count_nz) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + 1'b1;
        end
    end

    // FORCE always lasts one cycle: it either drains the head or, if a RUN-cycle
    // drain on the way in emptied the queue, has nothing left to wait for.
    always_comb begin
        state_d    = ST_RUN;
        redirect_d = redirect_q;
        if (mis_acc) begin
            state_d    = ST_FLUSH;
            redirect_d = enq_tgt;
        end else if ((state_q == ST_RUN) &&
                     ((count_q == FULL_CNT) || (count_nz && (age_q == AGE_MAX)))) begin
            state_d = ST_FORCE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            age_q      <= '0;
            redirect_q <= '0;
            mem_pc_q   <= '{default: '0};
            mem_tgt_q  <= '{default: '0};
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            age_q      <= age_d;
            redirect_q <= redirect_d;
            mem_pc_q   <= mem_pc_d;
            mem_tgt_q  <= mem_tgt_d;
        end
    end

    assign bus.res_ready      = ready;
    assign bus.stall_fetch    = stall;
    assign bus.btb_access     = lookup_grant;
    assign bus.btb_lookup_pc  = lookup_grant ? bus.fetch_pc : '0;
    assign bus.pred_valid     = lookup_grant && bus.btb_found;
    assign bus.pred_target    = (lookup_grant && bus.btb_found) ? bus.btb_predict_pc : '0;
    assign bus.btb_update     = update_grant;
    assign bus.btb_upd_pc     = update_grant ? mem_pc_q[rd_ptr_q] : '0;
    assign bus.btb_upd_target = update_grant ? mem_tgt_q[rd_ptr_q] : '0;
    assign bus.flush          = (state_q == ST_FLUSH);
    assign bus.redirect_pc    = redirect_q;
endmodule
